// File: rtl/overlay_pkg.sv
// overlay_pkg -- shared definitions for the overlay source arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, LOCK)
//   IDLE_CNT_W  : width of the mid-packet idle counter (covers TIMEOUT up to 65535)
//   clog2w()    : index width helper, never returns less than 1 bit
package overlay_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int IDLE_CNT_W = 16;

    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick -- combinational round-robin requester search.
//   i_req    : request vector
//   i_ptr    : last served index; search starts at i_ptr+1 modulo N
//   o_onehot : one-hot of the picked requester (zero when none)
//   o_idx    : index of the picked requester
//   o_any    : at least one request present
module rr_priority_pick
    import overlay_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = clog2w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int w_cand;

    // Walk the N positions after the pointer; the pointer itself is visited
    // last so the previous owner only wins when nobody else is asking.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_cand]) begin
                o_any    = 1'b1;
                o_idx    = IDX_W'(w_cand);
                o_onehot = N'(1) << w_cand;
            end
        end
    end

endmodule

// File: rtl/overlay_src_arbiter.sv
// overlay_src_arbiter -- packet-locked round-robin arbiter feeding the overlay stream.
//   clk_clk, reset_reset            : clock, synchronous active-high reset
//   src_data/valid/eop/ready        : NUM_SRC requester streams (beat i at [i*DATA_W +: DATA_W])
//   src_enable                      : per-source grant mask, consulted only when picking
//   overlay_src_data/valid/eop/ready: registered output stream
//   grant_id                        : current / last granted source
//   timeout_pulse                   : one cycle when a stalled packet is forcibly released
module overlay_src_arbiter
    import overlay_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int DATA_W  = 64,
    parameter  int TIMEOUT = 1023,
    localparam int ID_W    = clog2w(NUM_SRC)
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_eop,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC-1:0]        src_enable,
    output logic [DATA_W-1:0]         overlay_src_data,
    output logic                      overlay_src_valid,
    output logic                      overlay_src_eop,
    input  logic                      overlay_src_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      timeout_pulse
);

    localparam logic [IDLE_CNT_W-1:0] TO_LIM = IDLE_CNT_W'(TIMEOUT);

    arb_state_e            r_state, w_state_nxt;
    logic [ID_W-1:0]       r_grant, r_rr_ptr, w_pick_idx;
    logic [NUM_SRC-1:0]    r_grant_oh, w_pick_oh;
    logic                  w_pick_any;
    logic [IDLE_CNT_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
    logic [DATA_W-1:0]     r_out_data;
    logic                  r_out_valid, r_out_eop, r_timeout;
    logic                  w_g_valid, w_g_eop, w_g_ready;
    logic                  w_accept, w_release, w_timeout;
    logic [DATA_W-1:0]     w_g_data;

    rr_priority_pick #(.N(NUM_SRC)) u_pick (
        .i_req    (src_valid & src_enable),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_g_valid = src_valid[r_grant];
    assign w_g_eop   = src_eop[r_grant];
    assign w_g_data  = src_data[r_grant*DATA_W +: DATA_W];
    // Output register can take a new beat when empty or draining this cycle.
    assign w_g_ready = ~r_out_valid | overlay_src_ready;

    always_comb begin
        w_state_nxt    = r_state;
        src_ready      = '0;
        w_accept       = 1'b0;
        w_release      = 1'b0;
        w_timeout      = 1'b0;
        w_idle_cnt_nxt = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) w_state_nxt = LOCK;
            end
            LOCK: begin
                // Held low during reset so no source believes a beat was taken
                // in the cycle the packet is being abandoned.
                if (!reset_reset) src_ready = r_grant_oh & {NUM_SRC{w_g_ready}};
                w_accept = w_g_valid & w_g_ready;
                // Counts consecutive empty cycles only; a valid beat (taken or
                // stalled by the output) restarts the count.
                if (!w_g_valid)
                    w_idle_cnt_nxt = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + 1'b1;
                if (w_accept && w_g_eop) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!w_g_valid && w_idle_cnt_nxt >= TO_LIM) begin
                    // Abandon the packet with no synthetic eop.
                    w_timeout   = 1'b1;
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_oh  <= '0;
            r_rr_ptr    <= ID_W'(NUM_SRC - 1);
            r_idle_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_out_data  <= '0;
            r_out_eop   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_release ? '0 : w_idle_cnt_nxt;
            r_timeout  <= w_timeout;
            if (r_state == IDLE && w_pick_any) begin
                r_grant    <= w_pick_idx;
                r_grant_oh <= w_pick_oh;
            end
            if (w_release) r_rr_ptr <= r_grant;
            // Release and output drain are independent: an eop beat taken while
            // the output stalls still frees the grant.
            if (w_accept) begin
                r_out_data  <= w_g_data;
                r_out_eop   <= w_g_eop;
                r_out_valid <= 1'b1;
            end else if (overlay_src_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign overlay_src_data  = r_out_data;
    assign overlay_src_valid = r_out_valid;
    assign overlay_src_eop   = r_out_eop;
    assign grant_id          = r_grant;
    assign timeout_pulse     = r_timeout;

endmodule

// File: tb/tb_overlay_src_arbiter.sv
module tb_overlay_src_arbiter;

    localparam int NS = 4;
    localparam int DW = 64;
    localparam int TO = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          eop;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]    src_valid, src_eop, src_ready, src_enable;
    logic [DW-1:0]    o_data;
    logic             o_valid, o_eop, o_ready;
    logic [1:0]       gid;
    logic             tpulse;

    beat_t srcq [NS][$];
    beat_t exp_q[$];
    int    errors  = 0;
    int    checks  = 0;
    int    acc_cnt = 0;

    overlay_src_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_clk           (clk),
        .reset_reset       (rst),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_eop           (src_eop),
        .src_ready         (src_ready),
        .src_enable        (src_enable),
        .overlay_src_data  (o_data),
        .overlay_src_valid (o_valid),
        .overlay_src_eop   (o_eop),
        .overlay_src_ready (o_ready),
        .grant_id          (gid),
        .timeout_pulse     (tpulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic beat_t mk(input int s, input int p, input int b, input logic e);
        beat_t r;
        r.data = 64'hC0DE_0000_0000_0000 | 64'(s * 256 + p * 16 + b);
        r.eop  = e;
        return r;
    endfunction

    // queue an n-beat packet on source s
    task automatic add(input int s, input int p, input int n, input logic last_eop);
        for (int b = 0; b < n; b++) srcq[s].push_back(mk(s, p, b, (b == n - 1) ? last_eop : 1'b0));
    endtask

    // expect beats b0..n-1 of that packet on the output
    task automatic expect_pkt(input int s, input int p, input int b0, input int n, input logic last_eop);
        for (int b = b0; b < n; b++) exp_q.push_back(mk(s, p, b, (b == n - 1) ? last_eop : 1'b0));
    endtask

    task automatic wait_exp(input string name, input int max);
        int c = 0;
        while (exp_q.size() != 0 && c < max) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(name, exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_acc(input int target, input int max);
        int c = 0;
        while (acc_cnt < target && c < max) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("accept_wait", acc_cnt >= target, 64'(acc_cnt), 64'(target));
    endtask

    // source driver: present queue heads, pop what the DUT took at the edge
    initial begin
        logic [NS-1:0] acc;
        acc       = '0;
        src_valid = '0;
        src_eop   = '0;
        src_data  = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NS; i++)
                if (acc[i]) begin
                    void'(srcq[i].pop_front());
                    acc_cnt++;
                end
            #2;
            for (int i = 0; i < NS; i++) begin
                src_valid[i] = (srcq[i].size() != 0);
                if (srcq[i].size() != 0) begin
                    src_data[i*DW +: DW] = srcq[i][0].data;
                    src_eop[i]           = srcq[i][0].eop;
                end else begin
                    src_data[i*DW +: DW] = '0;
                    src_eop[i]           = 1'b0;
                end
            end
            #1 acc = src_valid & src_ready;
        end
    end

    // output monitor / scoreboard
    initial begin
        beat_t held, e;
        logic  stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", o_valid, 64'(o_valid), 64'd1);
                    chk("hold_data", o_data == held.data && o_eop == held.eop, o_data, held.data);
                end
                if (o_valid && o_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1'b0, o_data, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", o_data == e.data, o_data, e.data);
                        chk("out_eop", o_eop == e.eop, 64'(o_eop), 64'(e.eop));
                    end
                end else if (o_valid) begin
                    chk("stall_src_ready", src_ready == '0, 64'(src_ready), 64'd0);
                    stalled   = 1'b1;
                    held.data = o_data;
                    held.eop  = o_eop;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, c;
        logic found;
        logic [63:0] d3 [3];
        o_ready    = 1'b1;
        src_enable = '1;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o_valid == 1'b0, 64'(o_valid), 64'd0);
        chk("rst_eop", o_eop == 1'b0, 64'(o_eop), 64'd0);
        chk("rst_data", o_data == '0, o_data, 64'd0);
        chk("rst_src_ready", src_ready == '0, 64'(src_ready), 64'd0);
        chk("rst_grant", gid == 2'd0, 64'(gid), 64'd0);
        chk("rst_tpulse", tpulse == 1'b0, 64'(tpulse), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // fairness: all valid, pointer starts at 3 -> 0,1,2,3,0
        add(0, 0, 2, 1'b1); add(0, 1, 2, 1'b1);
        add(1, 0, 2, 1'b1); add(2, 0, 2, 1'b1); add(3, 0, 2, 1'b1);
        expect_pkt(0, 0, 0, 2, 1'b1); expect_pkt(1, 0, 0, 2, 1'b1);
        expect_pkt(2, 0, 0, 2, 1'b1); expect_pkt(3, 0, 0, 2, 1'b1);
        expect_pkt(0, 1, 0, 2, 1'b1);
        wait_exp("fair_drain", 200);

        // single source, one-beat latency, back-to-back acceptance
        d3[0] = 64'h11; d3[1] = 64'h22; d3[2] = 64'h33;
        for (int i = 0; i < 3; i++) begin
            beat_t bt;
            bt.data = d3[i];
            bt.eop  = (i == 2);
            srcq[0].push_back(bt);
            exp_q.push_back(bt);
        end
        base = acc_cnt;
        wait_acc(base + 1, 50);
        @(negedge clk);
        chk("latency_valid", o_valid == 1'b1, 64'(o_valid), 64'd1);
        chk("latency_data", o_data == 64'h11, o_data, 64'h11);
        repeat (2) @(posedge clk);
        #1;
        chk("throughput", acc_cnt == base + 3, 64'(acc_cnt - base), 64'd3);
        wait_exp("single_drain", 50);
        chk("single_grant", gid == 2'd0, 64'(gid), 64'd0);

        // reset mid-packet: src2 wins (ptr 0), reset on its 2nd beat,
        // then src0 wins because the pointer is back at NUM_SRC-1
        add(2, 0, 3, 1'b1); add(0, 0, 2, 1'b1);
        expect_pkt(0, 0, 0, 2, 1'b1); expect_pkt(2, 0, 1, 3, 1'b1);
        base = acc_cnt;
        wait_acc(base + 1, 50);
        chk("pre_rst_grant", gid == 2'd2, 64'(gid), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", o_valid == 1'b0, 64'(o_valid), 64'd0);
        chk("post_rst_ready", src_ready == '0, 64'(src_ready), 64'd0);
        wait_exp("rst_drain", 100);

        // backpressure: 5 stalled cycles mid-packet on src3
        add(3, 0, 4, 1'b1);
        expect_pkt(3, 0, 0, 4, 1'b1);
        base = acc_cnt;
        wait_acc(base + 2, 50);
        o_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_no_accept", acc_cnt == base + 2, 64'(acc_cnt - base), 64'd2);
        o_ready = 1'b1;
        wait_exp("bp_drain", 100);

        // timeout: src1 sends one beat then goes quiet; src2 waits behind it
        add(1, 0, 1, 1'b0);
        expect_pkt(1, 0, 0, 1, 1'b0);
        base = acc_cnt;
        wait_acc(base + 1, 50);
        add(2, 1, 2, 1'b1);
        expect_pkt(2, 1, 0, 2, 1'b1);
        c = 0;
        found = 1'b0;
        while (c < 20 && !found) begin
            @(posedge clk);
            #1;
            c++;
            if (tpulse) found = 1'b1;
        end
        chk("timeout_cycle", found && c == TO, 64'(c), 64'(TO));
        chk("timeout_idle", src_ready == '0, 64'(src_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("timeout_pulse_1cyc", tpulse == 1'b0, 64'(tpulse), 64'd0);
        chk("timeout_next_grant", gid == 2'd2, 64'(gid), 64'd2);
        wait_exp("to_drain", 100);

        // mask 1010: only 1 and 3 served, alternating from ptr 2
        src_enable = 4'b1010;
        add(0, 0, 2, 1'b1); add(1, 0, 2, 1'b1); add(1, 1, 2, 1'b1);
        add(2, 0, 2, 1'b1); add(3, 0, 2, 1'b1); add(3, 1, 2, 1'b1);
        expect_pkt(3, 0, 0, 2, 1'b1); expect_pkt(1, 0, 0, 2, 1'b1);
        expect_pkt(3, 1, 0, 2, 1'b1); expect_pkt(1, 1, 0, 2, 1'b1);
        wait_exp("mask_drain", 200);
        base = acc_cnt;
        repeat (4) @(posedge clk);
        #1;
        chk("mask_idle_ready", src_ready == '0, 64'(src_ready), 64'd0);
        chk("mask_idle_accept", acc_cnt == base, 64'(acc_cnt - base), 64'd0);
        // re-enable all, then pull src2's enable mid-packet: packet still completes
        expect_pkt(2, 0, 0, 2, 1'b1); expect_pkt(0, 0, 0, 2, 1'b1);
        src_enable = 4'b1111;
        wait_acc(base + 1, 50);
        src_enable = 4'b0001;
        wait_exp("enable_drop_drain", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
